// File: rtl/queue_push_arbiter.sv
// rtl/queue_push_arbiter.sv - round-robin push arbiter and occupancy controller for a shared circular_queue
// Drives all push/pop/reset inputs of an external queue that has no full/empty or flush of its own.
module queue_push_arbiter #(
  parameter int  NUM_REQ = 4,
  parameter int  DEPTH   = 8,
  parameter int  W       = 32,
  localparam int IDW     = $clog2(NUM_REQ),
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*W-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_grant,
  output logic                 q_push,
  output logic [IDW+W-1:0]     q_in,
  output logic                 q_pop,
  output logic                 q_n_rst,
  input  logic [IDW+W-1:0]     q_out,
  output logic                 deq_valid,
  input  logic                 deq_ready,
  output logic [W-1:0]         deq_data,
  output logic [IDW-1:0]       deq_src,
  output logic [CW-1:0]        count,
  output logic                 full,
  output logic                 empty
);

  logic [CW-1:0]      r_count;
  logic [IDW-1:0]     r_rr_ptr;

  logic               w_clear;
  logic               w_push_ok;
  logic               w_found;
  logic [IDW-1:0]     w_gnt_idx;
  logic [NUM_REQ-1:0] w_grant;
  logic [W-1:0]       w_gnt_data;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic               w_deq_valid;

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDW'(s);
  endfunction

  assign w_clear     = rst | flush;
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_empty     = (r_count == '0);
  // Gating on full alone (not full-minus-pop) keeps deq_ready off the grant path.
  assign w_push_ok   = ~w_full & ~w_clear;
  assign w_deq_valid = ~w_empty & ~w_clear;
  assign w_pop       = w_deq_valid & deq_ready;

  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_push_ok && !w_found && req_valid[wrap_add(r_rr_ptr, k)]) begin
        w_found   = 1'b1;
        w_gnt_idx = wrap_add(r_rr_ptr, k);
      end
    end
  end

  always_comb begin
    w_grant    = '0;
    w_gnt_data = '0;
    if (w_found) w_grant[w_gnt_idx] = 1'b1;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_found && (IDW'(k) == w_gnt_idx)) w_gnt_data = req_data[k*W +: W];
    end
  end

  assign w_push = w_found;

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_count  <= '0;
      r_rr_ptr <= '0;
    end else begin
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
      if (w_push) r_rr_ptr <= wrap_add(w_gnt_idx, 1);
    end
  end

  assign req_grant = w_grant;
  assign q_push    = w_push;
  assign q_in      = {w_gnt_idx, w_gnt_data};
  assign q_pop     = w_pop;
  assign q_n_rst   = ~w_clear;
  assign deq_valid = w_deq_valid;
  assign deq_data  = q_out[W-1:0];
  assign deq_src   = q_out[IDW+W-1:W];
  assign count     = r_count;
  assign full      = w_full;
  assign empty     = w_empty;

endmodule

// File: tb/tb_queue_push_arbiter.sv
// tb/tb_queue_push_arbiter.sv - self-checking bench for queue_push_arbiter with a behavioural queue and scoreboard
module tb_queue_push_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DEPTH   = 8;
  localparam int W       = 32;
  localparam int IDW     = $clog2(NUM_REQ);
  localparam int CW      = $clog2(DEPTH + 1);

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 flush = 1'b0;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [NUM_REQ*W-1:0] req_data = '0;
  logic [NUM_REQ-1:0]   req_grant;
  logic                 q_push;
  logic [IDW+W-1:0]     q_in;
  logic                 q_pop;
  logic                 q_n_rst;
  logic [IDW+W-1:0]     q_out;
  logic                 deq_valid;
  logic                 deq_ready = 1'b0;
  logic [W-1:0]         deq_data;
  logic [IDW-1:0]       deq_src;
  logic [CW-1:0]        count;
  logic                 full;
  logic                 empty;

  int n_tests = 0;
  int n_fail  = 0;

  queue_push_arbiter #(.NUM_REQ(NUM_REQ), .DEPTH(DEPTH), .W(W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_data(req_data), .req_grant(req_grant),
    .q_push(q_push), .q_in(q_in), .q_pop(q_pop), .q_n_rst(q_n_rst), .q_out(q_out),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_data(deq_data), .deq_src(deq_src),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural circular queue: modulo pointers, synchronous active-low reset, no full/empty.
  logic [IDW+W-1:0] qmem [DEPTH];
  int qh = 0;
  int qt = 0;
  always @(posedge clk) begin
    if (!q_n_rst) begin
      qh <= 0;
      qt <= 0;
    end else begin
      if (q_push) begin
        qmem[qt] <= q_in;
        qt <= (qt + 1) % DEPTH;
      end
      if (q_pop) qh <= (qh + 1) % DEPTH;
    end
  end
  assign q_out = qmem[qh];

  // Reference model, evaluated mid-cycle once inputs are settled.
  logic [IDW+W-1:0] sbq[$];
  int m_cnt = 0;
  int m_rr  = 0;
  always @(negedge clk) begin
    logic [NUM_REQ-1:0] eg;
    logic [IDW+W-1:0]   e;
    int gi;
    int idx;
    logic pop;
    if (rst || flush) begin
      check("clr_grant", 64'(req_grant), 64'(0));
      check("clr_push", 64'(q_push), 64'(0));
      check("clr_pop", 64'(q_pop), 64'(0));
      check("clr_deq_valid", 64'(deq_valid), 64'(0));
      check("clr_q_n_rst", 64'(q_n_rst), 64'(0));
      m_cnt = 0;
      m_rr  = 0;
      sbq.delete();
    end else begin
      check("count", 64'(count), 64'(m_cnt));
      check("full", 64'(full), 64'(m_cnt == DEPTH));
      check("empty", 64'(empty), 64'(m_cnt == 0));
      check("q_n_rst", 64'(q_n_rst), 64'(1));
      check("deq_valid", 64'(deq_valid), 64'(m_cnt != 0));
      pop = (m_cnt != 0) && deq_ready;
      check("q_pop", 64'(q_pop), 64'(pop));
      if (pop) begin
        if (sbq.size() == 0) begin
          check("sb_underflow", 64'(1), 64'(0));
        end else begin
          e = sbq.pop_front();
          check("deq_data", 64'(deq_data), 64'(e[W-1:0]));
          check("deq_src", 64'(deq_src), 64'(e[IDW+W-1:W]));
        end
      end
      eg = '0;
      gi = -1;
      if (m_cnt < DEPTH) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          idx = (m_rr + k) % NUM_REQ;
          if (gi < 0 && req_valid[idx]) gi = idx;
        end
      end
      if (gi >= 0) eg[gi] = 1'b1;
      check("req_grant", 64'(req_grant), 64'(eg));
      check("q_push", 64'(q_push), 64'(gi >= 0));
      if (gi >= 0) begin
        e = {IDW'(gi), req_data[gi*W +: W]};
        check("q_in", 64'(q_in), 64'(e));
        sbq.push_back(e);
        m_rr = (gi + 1) % NUM_REQ;
      end
      m_cnt = m_cnt + ((gi >= 0) ? 1 : 0) - (pop ? 1 : 0);
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_data(input int phase);
    for (int i = 0; i < NUM_REQ; i++) req_data[i*W +: W] = 32'(phase * 256 + i);
  endtask

  task automatic drain();
    req_valid = '0;
    deq_ready = 1'b1;
    tick(DEPTH + 2);
    check("drained", 64'(empty), 64'(1));
  endtask

  initial begin
    int n;
    int cyc;
    logic g;
    // Reset with all requesters asserting
    rst = 1'b1;
    req_valid = '1;
    set_data(1);
    tick(1);
    check("rst_grant_comb", 64'(req_grant), 64'(0));
    check("rst_q_n_rst_comb", 64'(q_n_rst), 64'(0));
    tick(1);
    rst = 1'b0;
    deq_ready = 1'b0;
    req_valid = '0;
    check("post_rst_count", 64'(count), 64'(0));
    check("post_rst_empty", 64'(empty), 64'(1));
    check("post_rst_full", 64'(full), 64'(0));
    req_valid = '1;
    #1;
    check("first_grant", 64'(req_grant), 64'(4'b0001));

    // Round robin with continuous dequeue
    deq_ready = 1'b1;
    set_data(2);
    tick(9);
    check("rr_count", 64'(count), 64'(1));
    drain();

    // Fill to full from requester 2
    set_data(3);
    req_valid = 4'b0100;
    deq_ready = 1'b0;
    tick(10);
    check("fill_count", 64'(count), 64'(DEPTH));
    check("fill_full", 64'(full), 64'(1));
    check("fill_grant0", 64'(req_grant), 64'(0));
    deq_ready = 1'b1;
    #1;
    check("full_pop_nogrant", 64'(req_grant), 64'(0));
    check("full_pop", 64'(q_pop), 64'(1));
    tick(1);
    deq_ready = 1'b0;
    check("after_pop_count", 64'(count), 64'(DEPTH - 1));
    #1;
    check("refill_grant", 64'(req_grant), 64'(4'b0100));
    tick(1);
    check("refill_count", 64'(count), 64'(DEPTH));
    drain();

    // Wrap: 12 sequential payloads from requester 1, consumer starts 3 cycles late
    n = 0;
    cyc = 0;
    deq_ready = 1'b0;
    while (n < 12 && cyc < 100) begin
      req_data[1*W +: W] = 32'(8'h10 + n);
      req_valid = 4'b0010;
      deq_ready = (cyc >= 3);
      @(negedge clk);
      g = req_grant[1];
      tick(1);
      if (g) n++;
      cyc++;
    end
    check("wrap_all_granted", 64'(n), 64'(12));
    drain();

    // Flush mid-operation at count 5
    set_data(4);
    req_valid = '1;
    deq_ready = 1'b0;
    tick(5);
    check("pre_flush_count", 64'(count), 64'(5));
    flush = 1'b1;
    deq_ready = 1'b1;
    #1;
    check("flush_grant", 64'(req_grant), 64'(0));
    check("flush_pop", 64'(q_pop), 64'(0));
    tick(1);
    flush = 1'b0;
    req_valid = '0;
    deq_ready = 1'b0;
    check("post_flush_count", 64'(count), 64'(0));
    check("post_flush_deq_valid", 64'(deq_valid), 64'(0));
    req_valid = '1;
    #1;
    check("post_flush_rr0", 64'(req_grant), 64'(4'b0001));
    req_valid = 4'b0001;
    req_data[0 +: W] = 32'hAA;
    tick(1);
    req_valid = '0;
    check("aa_valid", 64'(deq_valid), 64'(1));
    check("aa_data", 64'(deq_data), 64'(32'hAA));
    check("aa_src", 64'(deq_src), 64'(0));
    drain();

    // Simultaneous push and pop at DEPTH-1
    set_data(5);
    req_valid = 4'b0001;
    deq_ready = 1'b0;
    tick(DEPTH - 1);
    check("sim_pre_count", 64'(count), 64'(DEPTH - 1));
    deq_ready = 1'b1;
    #1;
    check("sim_grant", 64'(req_grant), 64'(4'b0001));
    check("sim_pop", 64'(q_pop), 64'(1));
    tick(1);
    check("sim_count", 64'(count), 64'(DEPTH - 1));
    check("sim_full", 64'(full), 64'(0));
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/queue_push_arbiter.md
Name: queue_push_arbiter

Overview:
- Controller that shares one circular_queue instance (the FIFO used in the out-of-order backend) between NUM_REQ producers and one consumer.
- Owns occupancy tracking, full/empty, round-robin push arbitration, requester-ID tagging, and flush sequencing.
- The queue itself has no full/empty or flush, so this block drives all of the queue's push, pop and reset inputs.
- Sits between dispatch-side producers and the consuming stage.

Parameters:
- NUM_REQ, 4, number of producers (>=2).
- DEPTH, 8, entries in the controlled queue; must equal the queue's L (>=2, need not be a power of 2).
- W, 32, payload width.
- IDW, derived $clog2(NUM_REQ), requester-ID width; not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  synchronous flush of queue and controller state.
- req_valid  in  NUM_REQ  producer i has an entry to push.
- req_data  in  NUM_REQ*W  payload; slice i = bits [i*W +: W].
- req_grant  out  NUM_REQ  one-hot-or-zero; producer i's data is consumed at this edge.
- q_push  out  1  to queue push.
- q_in  out  IDW+W  to queue in = {granted ID, granted payload}.
- q_pop  out  1  to queue pop.
- q_n_rst  out  1  to queue n_rst (active-low, synchronous) = ~(rst | flush).
- q_out  in  IDW+W  from queue out.
- deq_valid  out  1  head entry valid.
- deq_ready  in  1  consumer takes head this cycle.
- deq_data  out  W  = q_out[W-1:0].
- deq_src  out  IDW  = q_out[IDW+W-1:W].
- count  out  $clog2(DEPTH+1)  occupancy.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- **State:** count register, rr_ptr register (IDW bits). Nothing else sequential.
- **Reset (rst=1 at edge):** count=0, rr_ptr=0. While rst is high, the following are forced low combinationally: req_grant, q_push, q_pop, deq_valid, q_n_rst. full=0, empty=1 after the reset edge.
- **Flush (rst=0, flush=1):**
  - Same clearing as reset: count<=0, rr_ptr<=0.
  - req_grant, q_push, q_pop, deq_valid forced 0 in the flush cycle; q_n_rst=0 clears the queue pointers at the same edge.
  - flush has priority over any push or pop in that cycle.
- **Push eligibility:** push_ok = ~full & ~rst & ~flush. A push is never accepted when full, even if a pop occurs in the same cycle. This removes any deq_ready->req_grant combinational path.
- **Arbitration (combinational):**
  - If push_ok, grant the first i with req_valid[i], searching i = rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - At most one grant per cycle. q_push = |req_grant. q_in = {i, req_data slice i}.
  - On a grant to i: rr_ptr <= (i+1) mod NUM_REQ. With no grant, rr_ptr holds.
- **Dequeue:** deq_valid = ~empty & ~rst & ~flush; q_pop = deq_valid & deq_ready. deq_data and deq_src are combinational from q_out; they are valid only when deq_valid=1.
- **Latency:** an entry pushed at edge N is visible on deq_* from cycle N+1 (deq_valid=1 in the cycle after the grant when the queue was empty).
- **Count update:**
  - push only: count+1
  - pop only: count-1
  - both: unchanged
  - neither: unchanged
- **Invariants:** count never exceeds DEPTH and never underflows, so the queue's tail never overruns its head.
- **Simultaneous push and pop when count=DEPTH-1:** both occur, count stays DEPTH-1.
- **Empty:** pop is impossible; a push in that cycle is not bypassed to deq_*.
- **Wrap-around:** handled by the queue's modulo pointers. The controller needs only count, so a non-power-of-2 DEPTH is legal.
- **Producer contract:** req_valid/req_data must hold until granted. The arbiter never drops a held request; starvation bound is NUM_REQ-1 grants to others.

Test Plan:
- **Reset:** rst=1 for 2 cycles with all req_valid=1 -> req_grant=0, q_push=0, q_n_rst=0; after release count=0, empty=1, first grant goes to requester 0.
- **Round-robin:** NUM_REQ=4, all req_valid held, deq_ready=1 -> grants 0,1,2,3,0,...; deq_src follows the same sequence one cycle later; count stays at 1 after the first push.
- **Fill to full:** req_valid=4'b0100, deq_ready=0, DEPTH=8 -> 8 grants to requester 2, count=8, full=1, grant then 0. Next, one cycle of deq_ready=1 -> pop, count=7, no grant that cycle. The following cycle -> grant, count=8.
- **Wrap:** push 12 sequential payloads 0x10..0x1B while popping with a 3-cycle lag -> deq_data order is exactly 0x10..0x1B; count never exceeds 8.
- **Flush mid-operation:** count=5 with pending requests, flush=1 for one cycle -> no grant or pop that cycle; next cycle count=0, deq_valid=0, rr_ptr=0. A subsequent push of 0xAA then appears on deq_data with deq_valid=1.
- **Simultaneous push/pop at count=7:** push and pop in the same cycle -> count remains 7 and full stays 0.
